// File: rtl/wop_issue_seq_pkg.sv
// Core definitions shared by the wide-op issue path: uop slot layout and
// the canonical "empty lane" field values.
package wop_issue_seq_pkg;

  localparam int UOP_W    = 61;
  localparam int REG_W    = 7;
  localparam int IMM_W    = 32;
  localparam int UCMD_W   = 8;

  // Slot packing {RegN, RegS, RegT, Imm, UCmd}, UCmd in the low byte.
  localparam int UCMD_LSB = 0;
  localparam int IMM_LSB  = UCMD_LSB + UCMD_W;
  localparam int REGT_LSB = IMM_LSB + IMM_W;
  localparam int REGS_LSB = REGT_LSB + REG_W;
  localparam int REGN_LSB = REGS_LSB + REG_W;

  localparam logic [REG_W-1:0]  UREG_ZZR  = 7'h00;
  localparam logic [IMM_W-1:0]  UV32_XX   = 32'h0000_0000;
  localparam logic [UCMD_W-1:0] UCMD_NONE = 8'h00;

  function automatic logic [UOP_W-1:0] packUop(
    input logic [REG_W-1:0]  regN,
    input logic [REG_W-1:0]  regS,
    input logic [REG_W-1:0]  regT,
    input logic [IMM_W-1:0]  imm,
    input logic [UCMD_W-1:0] cmd
  );
    logic [UOP_W-1:0] uop;
    uop = '0;
    uop[REGN_LSB +: REG_W]  = regN;
    uop[REGS_LSB +: REG_W]  = regS;
    uop[REGT_LSB +: REG_W]  = regT;
    uop[IMM_LSB  +: IMM_W]  = imm;
    uop[UCMD_LSB +: UCMD_W] = cmd;
    return uop;
  endfunction

  function automatic logic [UCMD_W-1:0] uopCmd(input logic [UOP_W-1:0] uop);
    return uop[UCMD_LSB +: UCMD_W];
  endfunction

  localparam logic [UOP_W-1:0] UOP_IDLE =
    packUop(UREG_ZZR, UREG_ZZR, UREG_ZZR, UV32_XX, UCMD_NONE);

endpackage

// File: rtl/wop_issue_seq_slot_pick.sv
// Combinational priority picker: selects the lowest ISSUE_W set bits of a
// slot mask as one-hot selects and reports which mask bits were taken.
module wop_slot_pick #(
  parameter int MAX_OPS = 5,
  parameter int ISSUE_W = 2
) (
  input  logic [MAX_OPS-1:0]              mask,
  output logic [ISSUE_W-1:0][MAX_OPS-1:0] pick,
  output logic [ISSUE_W-1:0]              pickValid,
  output logic [MAX_OPS-1:0]              consumed
);

  logic [MAX_OPS-1:0] remain [ISSUE_W+1];

  assign remain[0] = mask;

  // Each stage isolates the lowest remaining bit and strips it for the next lane.
  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : genStage
    assign pick[gi]       = remain[gi] & (~remain[gi] + 1'b1);
    assign pickValid[gi]  = |remain[gi];
    assign remain[gi + 1] = remain[gi] & ~pick[gi];
  end

  assign consumed = mask & ~remain[ISSUE_W];

endmodule

// File: rtl/wop_issue_seq.sv
// Issue sequencer: holds one decoded wide-op bundle and drains it to the
// execute stage ISSUE_W uops per cycle, optionally compacting out empty slots.
module wop_issue_seq #(
  parameter int MAX_OPS = 5,
  parameter int ISSUE_W = 2,
  parameter int COMPACT = 1,
  parameter int UOP_W   = 61
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       inValid,
  output logic                       inReady,
  input  logic [MAX_OPS*UOP_W-1:0]   inOps,
  input  logic [3:0]                 inCount,
  output logic [ISSUE_W-1:0]         outValid,
  output logic [ISSUE_W*UOP_W-1:0]   outOps,
  input  logic                       outReady,
  input  logic                       flush,
  output logic                       busy
);
  import wop_issue_seq_pkg::*;

  localparam int N_GRP = (MAX_OPS + ISSUE_W - 1) / ISSUE_W;
  localparam int GRP_W = (N_GRP > 1) ? $clog2(N_GRP) : 1;
  localparam logic [UOP_W-1:0] IDLE_LANE = UOP_IDLE;

  typedef enum logic {ST_IDLE, ST_DRAIN} seqState_t;

  seqState_t                  stReg, stNext;
  logic [MAX_OPS-1:0]         pendReg, pendNext;
  logic [GRP_W-1:0]           grpReg, grpNext;
  logic [MAX_OPS*UOP_W-1:0]   holdReg;

  logic [3:0]                 liveCount;
  logic [MAX_OPS-1:0]         loadPend;
  logic [MAX_OPS-1:0]         slotLive;
  logic [MAX_OPS-1:0]         windowMask;
  logic [MAX_OPS-1:0]         pickMask;
  logic [MAX_OPS-1:0]         consumed;
  logic [MAX_OPS-1:0]         pendLeft;
  logic [ISSUE_W-1:0][MAX_OPS-1:0] pick;
  logic [ISSUE_W-1:0]         pickValid;
  logic                       drain;
  logic                       lastGroup;
  logic                       load;
  logic                       advance;

  function automatic logic [UOP_W-1:0] selectSlot(
    input logic [MAX_OPS*UOP_W-1:0] slots,
    input logic [MAX_OPS-1:0]       oneHot
  );
    logic [UOP_W-1:0] sel;
    sel = '0;
    for (int i = 0; i < MAX_OPS; i++) begin
      if (oneHot[i]) sel = sel | slots[i*UOP_W +: UOP_W];
    end
    return sel;
  endfunction

  assign liveCount = (inCount > 4'(MAX_OPS)) ? 4'(MAX_OPS) : inCount;

  for (genvar gi = 0; gi < MAX_OPS; gi++) begin : genSlot
    assign loadPend[gi]   = (4'(gi) < liveCount) &&
                            ((COMPACT == 0) || (uopCmd(inOps[gi*UOP_W +: UOP_W]) != UCMD_NONE));
    assign slotLive[gi]   = uopCmd(holdReg[gi*UOP_W +: UOP_W]) != UCMD_NONE;
    assign windowMask[gi] = (grpReg == GRP_W'(gi / ISSUE_W));
  end

  // Non-compact mode feeds the whole aligned window so lane j maps to slot grp*ISSUE_W+j.
  assign pickMask = (COMPACT != 0) ? pendReg : windowMask;

  wop_slot_pick #(
    .MAX_OPS (MAX_OPS),
    .ISSUE_W (ISSUE_W)
  ) picker (
    .mask      (pickMask),
    .pick      (pick),
    .pickValid (pickValid),
    .consumed  (consumed)
  );

  assign drain     = (stReg == ST_DRAIN);
  assign pendLeft  = pendReg & ~consumed;
  assign lastGroup = (pendLeft == '0);
  assign inReady   = !flush && (!drain || (outReady && lastGroup));
  assign busy      = drain;
  assign load      = inValid && inReady;
  assign advance   = outReady && drain;

  for (genvar gi = 0; gi < ISSUE_W; gi++) begin : genLane
    logic [UOP_W-1:0] laneUop;
    logic             laneOk;
    assign laneUop = selectSlot(holdReg, pick[gi]);
    assign laneOk  = drain && pickValid[gi] && (|(pick[gi] & pendReg & slotLive));
    assign outValid[gi]                 = laneOk;
    assign outOps[gi*UOP_W +: UOP_W]    = laneOk ? laneUop : IDLE_LANE;
  end

  // Load only happens from IDLE or on the last group's drain edge, so it may
  // overwrite pend outright; flush beats both load and advance.
  always_comb begin
    stNext   = stReg;
    pendNext = pendReg;
    grpNext  = grpReg;
    if (flush) begin
      stNext   = ST_IDLE;
      pendNext = '0;
      grpNext  = '0;
    end else if (load) begin
      pendNext = loadPend;
      grpNext  = '0;
      stNext   = (loadPend != '0) ? ST_DRAIN : ST_IDLE;
    end else if (advance) begin
      pendNext = pendLeft;
      grpNext  = grpReg + 1'b1;
      stNext   = lastGroup ? ST_IDLE : ST_DRAIN;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stReg   <= ST_IDLE;
      pendReg <= '0;
      grpReg  <= '0;
    end else begin
      stReg   <= stNext;
      pendReg <= pendNext;
      grpReg  <= grpNext;
    end
  end

  // Payload is only observed through pend, so it needs no reset.
  always_ff @(posedge clock) begin
    if (load) holdReg <= inOps;
  end

endmodule
